// File: rtl/rv_pkg.sv
// Shared RISC-V core types and constants used by the fetch stage.
package rv_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int XLEN        = 32;
    localparam int PC_INCR     = 4;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [XLEN-1:0]        pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory bus: valid/ready request channel plus in-order response channel.
interface instr_fetch_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [DATA_WIDTH-1:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic [31:0]           imem_rsp_data;

    // Fetch stage side
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    // Instruction memory side
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {instr, pc} entries; flush wins over push/pop.
module fetch_queue
    import rv_pkg::*;
#(
    parameter  int QUEUE_DEPTH = 2,
    localparam int PTR_W       = $clog2(QUEUE_DEPTH),
    localparam int CNT_W       = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       din,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   occupancy
);

    fetch_entry_t      entries_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop_eff;
    logic              push_eff;

    // A pop on empty or a push on full (without a same-cycle pop) is ignored.
    assign pop_eff  = pop && (count_q != '0);
    assign push_eff = push && ((count_q != CNT_W'(QUEUE_DEPTH)) || pop_eff);

    // Pointer and count update; pointers wrap naturally since depth is a power of two.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
        end
    end

    // Control state; reset leaves the queue empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (push_eff && !flush) begin
            entries_q[wr_ptr_q] <= din;
        end
    end

    assign head      = entries_q[rd_ptr_q];
    assign occupancy = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues sequential word requests, tracks in-flight responses,
// discards stale ones after a redirect, and presents {Instr, PC, PC+4} to decode.
module instr_fetch
    import rv_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
    parameter int                    QUEUE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PCSrc,
    input  logic [DATA_WIDTH-1:0] PCTarget,
    instr_fetch_if.master         imem,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           Instr,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] PCPlus4
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      kill_q, kill_d;
    logic                  run_q, run_d;

    logic [CNT_W-1:0]      occupancy;
    fetch_entry_t          head;
    fetch_entry_t          push_entry;
    logic [CNT_W:0]        inflight_total;
    logic                  credit_ok;
    logic                  req_fire;
    logic                  rsp_take;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  unused_pctarget_lsbs;

    // Low address bits of the redirect target are don't-care.
    assign unused_pctarget_lsbs = ^PCTarget[1:0];
    assign redirect_pc          = {PCTarget[DATA_WIDTH-1:2], 2'b00};

    // Credits cover both in-flight requests (including doomed ones) and queued entries,
    // so a response always has a free slot when it arrives.
    assign inflight_total = {1'b0, outstanding_q} + {1'b0, occupancy};
    assign credit_ok      = inflight_total < (CNT_W+1)'(QUEUE_DEPTH);

    // run_q holds off the first request until one edge after reset release.
    assign imem.imem_req_valid = run_q && !PCSrc && credit_ok;
    assign imem.imem_req_addr  = fetch_pc_q;

    assign req_fire = imem.imem_req_valid && imem.imem_req_ready;
    assign rsp_take = imem.imem_rsp_valid && (outstanding_q != '0);
    assign push     = rsp_take && (kill_q == '0) && !PCSrc;
    assign pop      = out_valid && out_ready && !PCSrc;

    assign push_entry.instr = imem.imem_rsp_data;
    assign push_entry.pc    = rsp_pc_q;

    // Next-state for PCs and credit counters; a redirect overrides everything else.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        kill_d        = kill_q;
        run_d         = 1'b1;
        if (PCSrc) begin
            fetch_pc_d    = redirect_pc;
            rsp_pc_d      = redirect_pc;
            outstanding_d = outstanding_q - CNT_W'(rsp_take);
            kill_d        = outstanding_q - CNT_W'(rsp_take);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + DATA_WIDTH'(PC_INCR);
            if (push)     rsp_pc_d   = rsp_pc_q + DATA_WIDTH'(PC_INCR);
            outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_take);
            if (rsp_take && (kill_q != '0)) kill_d = kill_q - CNT_W'(1);
        end
    end

    // Fetch state registers; reset abandons everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            kill_q        <= '0;
            run_q         <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
            run_q         <= run_d;
        end
    end

    fetch_queue #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (PCSrc),
        .din       (push_entry),
        .head      (head),
        .occupancy (occupancy)
    );

    // With an empty queue show a NOP at the next expected PC (RESET_PC under reset).
    assign out_valid = (occupancy != '0);
    assign Instr     = out_valid ? head.instr : NOP_INSTR;
    assign PC        = out_valid ? head.pc    : rsp_pc_q;
    assign PCPlus4   = PC + DATA_WIDTH'(PC_INCR);

endmodule
